// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - Shared encodings for the SRAM physical sequencer
package mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LO_SETUP,
      LO_ACCESS,
      HI_SETUP,
      HI_ACCESS,
      DONE
   } state_e;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   // SRAM control pins are all active low
   localparam logic SRAM_ACT   = 1'b0;
   localparam logic SRAM_INACT = 1'b1;

endpackage

// File: rtl/sram_phy.sv
// rtl/sram_phy.sv - Splits one 32-bit request into two 16-bit asynchronous SRAM half-accesses
module sram_phy
   import mem_pkg::*;
#(
   parameter int ADDR_W      = 18,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_en,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_be,
   output logic              ready,
   output logic              done,
   output logic [31:0]       rsp_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   inout  logic [15:0]       ram_data,
   output logic              ram_wre,
   output logic              ram_oute,
   output logic              ram_hb_mask,
   output logic              ram_lb_mask,
   output logic              ram_chip_en
);

   localparam logic [3:0]        WAIT_LOAD = 4'(WAIT_CYCLES - 1);
   localparam logic [ADDR_W-1:0] HALF_BIT  = ADDR_W'(1);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              active, access, hi, data_oe;
   logic [15:0]       data_out;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rw_q    <= RW_READ;
         base_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (req_en) state_d = LO_SETUP;
         LO_SETUP:  state_d = LO_ACCESS;
         LO_ACCESS: if (cnt_q == 4'd0) state_d = HI_SETUP;
         HI_SETUP:  state_d = HI_ACCESS;
         HI_ACCESS: if (cnt_q == 4'd0) state_d = DONE;
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Capture, wait counter and read sampling; the address register moves to the
   // high half on the edge leaving LO_ACCESS so HI_SETUP already presents it.
   always_comb begin
      cnt_d   = cnt_q;
      rw_d    = rw_q;
      base_d  = base_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (req_en) begin
               rw_d    = req_rw;
               base_d  = req_addr & ~HALF_BIT;
               addr_d  = req_addr & ~HALF_BIT;
               wdata_d = req_wdata;
               be_d    = req_be;
            end
         end
         LO_SETUP, HI_SETUP: cnt_d = WAIT_LOAD;
         LO_ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               addr_d = base_q | HALF_BIT;
               if (rw_q == RW_READ) rdata_d[15:0] = ram_data;
            end
         end
         HI_ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (rw_q == RW_READ) begin
               rdata_d[31:16] = ram_data;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      active      = (state_q inside {LO_SETUP, LO_ACCESS, HI_SETUP, HI_ACCESS});
      access      = (state_q inside {LO_ACCESS, HI_ACCESS});
      hi          = (state_q inside {HI_SETUP, HI_ACCESS});
      ready       = (state_q == IDLE);
      done        = (state_q == DONE);
      ram_chip_en = active ? SRAM_ACT : SRAM_INACT;
      ram_wre     = (access && rw_q == RW_WRITE) ? SRAM_ACT : SRAM_INACT;
      ram_oute    = (active && rw_q == RW_READ) ? SRAM_ACT : SRAM_INACT;
      data_oe     = active && (rw_q == RW_WRITE);
      data_out    = hi ? wdata_q[31:16] : wdata_q[15:0];
      ram_lb_mask = 1'b0;
      ram_hb_mask = 1'b0;
      if (access && rw_q == RW_WRITE) begin
         ram_lb_mask = hi ? ~be_q[2] : ~be_q[0];
         ram_hb_mask = hi ? ~be_q[3] : ~be_q[1];
      end
   end

   assign ram_data  = data_oe ? data_out : 16'hzzzz;
   assign ram_addr  = addr_q;
   assign rsp_rdata = rdata_q;

endmodule
